// File: rtl/addsub_sequencer_pkg.sv
// rtl/addsub_sequencer_pkg.sv - shared state encoding and control codes for the add/sub sequencer
package addsub_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_SET     = 3'd2,
      ST_EXEC    = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_FINISH  = 3'd5
   } state_t;

   localparam logic [1:0] SEL_B    = 2'b00;
   localparam logic [1:0] SEL_C    = 2'b01;
   localparam logic [1:0] SEL_D    = 2'b10;
   localparam logic [1:0] SEL_HOLD = 2'b11;

   localparam logic ADD = 1'b1;
   localparam logic SUB = 1'b0;

   // Operand step k (0..2) maps to B, C, D; anything else parks the mux on HOLD.
   function automatic logic [1:0] sel_code(input logic [1:0] k);
      case (k)
         2'd0:    sel_code = SEL_B;
         2'd1:    sel_code = SEL_C;
         2'd2:    sel_code = SEL_D;
         default: sel_code = SEL_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/addsub_sequencer_step_timer.sv
// rtl/addsub_sequencer_step_timer.sv - settle-time down-counter with load and last-cycle flag
module addsub_sequencer_step_timer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   output logic last
);

   localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

   logic [3:0] cnt;

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign last = (cnt == 4'd0);

endmodule

// File: rtl/addsub_sequencer.sv
// rtl/addsub_sequencer.sv - control sequencer driving the multicycle add/sub datapath
module addsub_sequencer
   import addsub_sequencer_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op_mask,
   input  logic [1:0]       op_count,
   input  logic [WIDTH-1:0] acc_in,
   output logic             s0,
   output logic             s1,
   output logic             s2,
   output logic             addOrSub,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             result_valid
);

   state_t     state, state_nxt;
   logic [1:0] k, k_nxt;
   logic [2:0] mask_q;
   logic [1:0] count_q;
   logic       timer_load;
   logic       timer_last;

   logic       s0_d, add_d, done_d, busy_d, valid_d;
   logic [1:0] sel_d, sel_q;

   assign timer_load = (state == ST_SET);

   addsub_sequencer_step_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_step_timer (
      .clock(clock),
      .reset(reset),
      .load (timer_load),
      .last (timer_last)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= ST_IDLE;
         k       <= 2'd0;
         mask_q  <= 3'd0;
         count_q <= 2'd0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         if (state == ST_IDLE && start) begin
            mask_q  <= op_mask;
            count_q <= op_count;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LOAD;
               k_nxt     = 2'd0;
            end
         end
         ST_LOAD:    state_nxt = (count_q != 2'd0) ? ST_SET : ST_CAPTURE;
         ST_SET:     state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (timer_last) begin
               k_nxt     = k + 2'd1;
               state_nxt = (k + 2'd1 == count_q) ? ST_CAPTURE : ST_SET;
            end
         end
         ST_CAPTURE: state_nxt = ST_FINISH;
         ST_FINISH:  state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered controls line up with the state.
   always_comb begin
      s0_d    = 1'b1;
      sel_d   = SEL_HOLD;
      add_d   = addOrSub;
      done_d  = 1'b1;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      case (state_nxt)
         ST_IDLE: begin
            s0_d   = 1'b0;
            add_d  = ADD;
            busy_d = 1'b0;
         end
         ST_LOAD: begin
            s0_d  = 1'b0;
            add_d = ADD;
         end
         ST_SET:    add_d   = mask_q[k_nxt];
         ST_EXEC: begin
            sel_d  = sel_code(k_nxt);
            done_d = 1'b0;
         end
         ST_FINISH: valid_d = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s0           <= 1'b0;
         sel_q        <= SEL_HOLD;
         addOrSub     <= ADD;
         done         <= 1'b1;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
      end else begin
         s0           <= s0_d;
         sel_q        <= sel_d;
         addOrSub     <= add_d;
         done         <= done_d;
         busy         <= busy_d;
         result_valid <= valid_d;
         if (state == ST_CAPTURE) begin
            result <= acc_in;
         end
      end
   end

   assign s1 = sel_q[0];
   assign s2 = sel_q[1];

endmodule

// File: tb/tb_addsub_sequencer.sv
// tb/tb_addsub_sequencer.sv - scoreboard bench for addsub_sequencer with a behavioural datapath
module tb_addsub_sequencer;

   typedef struct {
      logic [7:0] res;
      int         cyc;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] start_v;
   logic [2:0] mask_v [2];
   logic [1:0] cnt_v  [2];
   logic [7:0] acc_v  [2];
   logic [7:0] a_v    [2];
   logic [7:0] b_v    [2];
   logic [7:0] c_v    [2];
   logic [7:0] d_v    [2];
   logic [1:0] prev_sel [2];
   logic [1:0] s0_v, s1_v, s2_v, aos_v, done_v, busy_v, rv_v;
   logic [7:0] res_v [2];

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   exp_t mon_e;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   addsub_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) dut0 (
      .clock(clock), .reset(reset), .start(start_v[0]), .op_mask(mask_v[0]),
      .op_count(cnt_v[0]), .acc_in(acc_v[0]), .s0(s0_v[0]), .s1(s1_v[0]), .s2(s2_v[0]),
      .addOrSub(aos_v[0]), .done(done_v[0]), .busy(busy_v[0]), .result(res_v[0]),
      .result_valid(rv_v[0])
   );

   addsub_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3)) dut1 (
      .clock(clock), .reset(reset), .start(start_v[1]), .op_mask(mask_v[1]),
      .op_count(cnt_v[1]), .acc_in(acc_v[1]), .s0(s0_v[1]), .s1(s1_v[1]), .s2(s2_v[1]),
      .addOrSub(aos_v[1]), .done(done_v[1]), .busy(busy_v[1]), .result(res_v[1]),
      .result_valid(rv_v[1])
   );

   // Datapath: A loads while s0=0; one add/sub per select transition out of HOLD while done=0.
   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         logic [7:0] opnd;
         case ({s2_v[i], s1_v[i]})
            2'b00:   opnd = b_v[i];
            2'b01:   opnd = c_v[i];
            default: opnd = d_v[i];
         endcase
         prev_sel[i] <= {s2_v[i], s1_v[i]};
         if (!s0_v[i]) acc_v[i] <= a_v[i];
         else if (!done_v[i] && {s2_v[i], s1_v[i]} != 2'b11 && prev_sel[i] == 2'b11)
            acc_v[i] <= aos_v[i] ? acc_v[i] + opnd : acc_v[i] - opnd;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] a, b, c, d,
                                        input logic [2:0] m, input logic [1:0] n);
      logic [7:0] acc;
      acc = a;
      if (n > 2'd0) acc = m[0] ? acc + b : acc - b;
      if (n > 2'd1) acc = m[1] ? acc + c : acc - c;
      if (n > 2'd2) acc = m[2] ? acc + d : acc - d;
      return acc;
   endfunction

   always @(negedge clock) begin
      if (rv_v[0]) begin
         if (sb0.size() == 0) check_eq("dut0_spurious_valid", {31'd0, rv_v[0]}, 32'd0);
         else begin
            mon_e = sb0.pop_front();
            check_eq("dut0_result", {24'd0, res_v[0]}, {24'd0, mon_e.res});
            check_eq("dut0_valid_cycle", cyc, mon_e.cyc);
         end
      end
      if (rv_v[1]) begin
         if (sb1.size() == 0) check_eq("dut1_spurious_valid", {31'd0, rv_v[1]}, 32'd0);
         else begin
            mon_e = sb1.pop_front();
            check_eq("dut1_result", {24'd0, res_v[1]}, {24'd0, mon_e.res});
            check_eq("dut1_valid_cycle", cyc, mon_e.cyc);
         end
      end
   end

   // Drives one request, held long enough for nops back-to-back acceptances from IDLE.
   task automatic launch(input int i, input logic [7:0] a, b, c, d,
                         input logic [2:0] m, input logic [1:0] n, input int nops);
      int   lat;
      int   c0;
      exp_t e;
      lat = 3 + int'(n) * (1 + ((i == 0) ? 1 : 3));
      a_v[i] = a; b_v[i] = b; c_v[i] = c; d_v[i] = d;
      mask_v[i] = m; cnt_v[i] = n;
      start_v[i] = 1'b1;
      @(posedge clock); #1;
      c0 = cyc;
      for (int k = 0; k < nops; k++) begin
         e.res = model(a, b, c, d, m, n);
         e.cyc = c0 + k * (lat + 1) + lat - 1;
         if (i == 0) sb0.push_back(e);
         else        sb1.push_back(e);
      end
      repeat ((nops - 1) * (lat + 1)) @(posedge clock);
      #1 start_v[i] = 1'b0;
   endtask

   task automatic drain(input int i);
      for (int t = 0; t < 300; t++) begin
         if ((i == 0 ? sb0.size() : sb1.size()) == 0) break;
         @(posedge clock);
      end
      check_eq(i == 0 ? "dut0_drain" : "dut1_drain", i == 0 ? sb0.size() : sb1.size(), 0);
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] seq_exp [8];
      int         low;
      int         run;
      int         runs[$];

      reset = 1'b0;
      start_v = 2'b00;
      for (int i = 0; i < 2; i++) begin
         mask_v[i] = 3'd0; cnt_v[i] = 2'd0;
         a_v[i] = 8'd0; b_v[i] = 8'd0; c_v[i] = 8'd0; d_v[i] = 8'd0;
      end
      repeat (3) @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq("rst_s0",    {31'd0, s0_v[i]}, 32'd0);
         check_eq("rst_sel",   {30'd0, s2_v[i], s1_v[i]}, 32'd3);
         check_eq("rst_aos",   {31'd0, aos_v[i]}, 32'd1);
         check_eq("rst_done",  {31'd0, done_v[i]}, 32'd1);
         check_eq("rst_busy",  {31'd0, busy_v[i]}, 32'd0);
         check_eq("rst_valid", {31'd0, rv_v[i]}, 32'd0);
         check_eq("rst_result", {24'd0, res_v[i]}, 32'd0);
      end
      reset = 1'b1;
      @(posedge clock); #1;

      // Full three-operand sequence with select trace.
      seq_exp = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
      launch(0, 8'd10, 8'd3, 8'd4, 8'd5, 3'b101, 2'd3, 1);
      for (int t = 0; t < 8; t++) begin
         @(negedge clock);
         check_eq($sformatf("seq_sel_%0d", t), {30'd0, s2_v[0], s1_v[0]}, {30'd0, seq_exp[t]});
      end
      drain(0);

      // op_count=0: A passes straight through, done never drops.
      launch(0, 8'hF9, 8'd1, 8'd1, 8'd1, 3'b111, 2'd0, 1);
      low = 0;
      for (int t = 0; t < 3; t++) begin
         @(negedge clock);
         if (!done_v[0]) low++;
      end
      check_eq("oc0_done_low", low, 0);
      drain(0);

      launch(0, 8'd120, 8'd10, 8'd0, 8'd0, 3'b001, 2'd1, 1);
      drain(0);
      launch(0, 8'h80, 8'd1, 8'd0, 8'd0, 3'b000, 2'd1, 1);
      drain(0);

      // start held through FINISH: exactly two operations.
      launch(0, 8'd20, 8'd7, 8'd2, 8'd1, 3'b011, 2'd3, 2);
      drain(0);
      repeat (12) @(posedge clock);
      #1;

      // Inputs changed mid-operation must not affect the latched request.
      launch(0, 8'd50, 8'd5, 8'd6, 8'd7, 3'b010, 2'd3, 1);
      mask_v[0] = 3'b101;
      cnt_v[0]  = 2'd1;
      drain(0);

      // Reset in EXEC aborts with no result pulse.
      a_v[0] = 8'd9; b_v[0] = 8'd9; mask_v[0] = 3'b111; cnt_v[0] = 2'd3;
      start_v[0] = 1'b1;
      @(posedge clock); #1 start_v[0] = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_eq("midrst_s0",     {31'd0, s0_v[0]}, 32'd0);
      check_eq("midrst_sel",    {30'd0, s2_v[0], s1_v[0]}, 32'd3);
      check_eq("midrst_aos",    {31'd0, aos_v[0]}, 32'd1);
      check_eq("midrst_done",   {31'd0, done_v[0]}, 32'd1);
      check_eq("midrst_busy",   {31'd0, busy_v[0]}, 32'd0);
      check_eq("midrst_valid",  {31'd0, rv_v[0]}, 32'd0);
      check_eq("midrst_result", {24'd0, res_v[0]}, 32'd0);
      reset = 1'b1;
      repeat (12) @(posedge clock);
      #1;
      launch(0, 8'd1, 8'd2, 8'd3, 8'd4, 3'b110, 2'd2, 1);
      drain(0);

      // SETTLE_CYCLES=3: each EXEC lasts three cycles.
      launch(1, 8'd30, 8'd10, 8'd5, 8'd0, 3'b001, 2'd2, 1);
      run = 0;
      for (int t = 0; t < 12; t++) begin
         @(negedge clock);
         if (!done_v[1]) run++;
         else if (run > 0) begin
            runs.push_back(run);
            run = 0;
         end
      end
      check_eq("s3_exec_runs", runs.size(), 2);
      if (runs.size() == 2) begin
         check_eq("s3_exec_len0", runs[0], 3);
         check_eq("s3_exec_len1", runs[1], 3);
      end
      drain(1);
      launch(1, 8'd10, 8'd3, 8'd4, 8'd5, 3'b101, 2'd3, 1);
      drain(1);

      repeat (5) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
